// File: rtl/siso_pkg.sv
// Shared types and line levels for the serial frame controller.
// Contents: frame FSM state enum, idle/start/stop line levels.
// No ports; imported by siso_frame_ctrl and its interface users.
package siso_pkg;

  // Frame sequencing states, in transmit order.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Line levels: the line rests high, the start bit pulls it low,
  // and the stop bit returns it high.
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/siso_frame_ctrl_if.sv
// Producer-side handshake plus serial-line status bundle for siso_frame_ctrl.
// Ports: in_data/in_valid (producer -> ctrl), in_ready (ctrl -> producer),
//        dout/busy/done (ctrl -> consumer/observer).
interface siso_frame_ctrl_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             dout;
  logic             busy;
  logic             done;

  // Producer side: offers words, watches the line.
  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  dout,
    input  busy,
    input  done
  );

  // Controller side.
  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output dout,
    output busy,
    output done
  );

endinterface

// File: rtl/siso_shreg.sv
// Parallel-load, shift-right-on-enable register; serial output is bit 0.
// Ports: clk, reset (sync, active-low), load, shift_en, pdata[WIDTH], sout.
// Load has priority over shift; zeros are shifted in at the MSB.
module siso_shreg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] pdata,
  output logic             sout
);

  logic [WIDTH-1:0] q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= pdata;
    end else if (shift_en) begin
      q <= q >> 1;
    end
  end

  assign sout = q[0];

endmodule

// File: rtl/siso_frame_ctrl.sv
// Serialises one WIDTH-bit word per frame: start, data LSB-first, optional
// even parity, stop; every bit held DIV cycles on a registered dout.
// Ports: clk, reset (sync, active-low), bus (slave modport: in_data/in_valid/
//        in_ready handshake, dout/busy/done line status).
module siso_frame_ctrl
  import siso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DIV       = 1,
  parameter int PARITY_EN = 1
) (
  input  logic               clk,
  input  logic               reset,
  siso_frame_ctrl_if.slave   bus
);

  localparam int BW = $clog2(WIDTH) + 1;
  localparam int DW = $clog2(DIV) + 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic            par_q;
  logic            dout_q, dout_d;
  logic            load, shift_en;
  logic            sout;
  logic            accept;
  logic            advance;

  siso_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .shift_en (shift_en),
    .pdata    (bus.in_data),
    .sout     (sout)
  );

  assign accept  = bus.in_valid && (state_q == IDLE);
  // A bit boundary is reached only when the divider sits at its last count.
  assign advance = (state_q != IDLE) && (div_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      par_q   <= 1'b0;
      dout_q  <= LINE_IDLE;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      dout_q  <= dout_d;
      if (accept) begin
        par_q <= ^bus.in_data;
      end
    end
  end

  // dout is registered, so the value for each new bit is chosen on the edge
  // that enters it. The shift register is shifted on that same edge, after
  // its bit 0 has been captured into dout; bit 0 then already holds the next
  // data bit when the following advance comes round.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    dout_d   = dout_q;
    load     = 1'b0;
    shift_en = 1'b0;

    if (state_q != IDLE) begin
      div_d = advance ? '0 : div_q + DW'(1);
    end

    unique case (state_q)
      IDLE: begin
        div_d  = '0;
        dout_d = LINE_IDLE;
        if (accept) begin
          state_d = START;
          load    = 1'b1;
          bit_d   = '0;
          dout_d  = START_LVL;
        end
      end
      START: begin
        if (advance) begin
          state_d  = DATA;
          bit_d    = '0;
          dout_d   = sout;
          shift_en = 1'b1;
        end
      end
      DATA: begin
        if (advance) begin
          if (bit_q == BIT_LAST) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              dout_d  = par_q;
            end else begin
              state_d = STOP;
              dout_d  = STOP_LVL;
            end
          end else begin
            bit_d    = bit_q + BW'(1);
            dout_d   = sout;
            shift_en = 1'b1;
          end
        end
      end
      PARITY: begin
        if (advance) begin
          state_d = STOP;
          dout_d  = STOP_LVL;
        end
      end
      STOP: begin
        if (advance) begin
          state_d = IDLE;
          dout_d  = LINE_IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        dout_d  = LINE_IDLE;
      end
    endcase
  end

  assign bus.in_ready = (state_q == IDLE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == STOP) && (div_q == DIV_LAST);
  assign bus.dout     = dout_q;

endmodule

// File: doc/siso_frame_ctrl.md
Name: siso_frame_ctrl

Overview:
Serialising controller that sequences a parallel-load shift register to transmit one framed word on a single-bit line.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Shifts it out LSB-first as: start bit, data bits, optional even-parity bit, stop bit.
- Each bit is held for DIV clock cycles.
- Sits between a parallel producer and any serial consumer of dout.

Parameters:
WIDTH, 4, data bits per frame (>=1)
DIV, 1, clock cycles each bit is held on dout (>=1)
PARITY_EN, 1, 1 = insert even-parity bit after data; 0 = omit it

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (reset=0 at a rising clk edge resets the block)
in_data  input  WIDTH  word to transmit
in_valid  input  1  producer has a word on in_data
in_ready  output  1  controller can accept a word this cycle
dout  output  1  serial line, registered
busy  output  1  frame in progress
done  output  1  one-cycle pulse in the final cycle of the stop bit

Behaviour:
- Reset (reset=0 at posedge):
  - State goes to IDLE; dout=1, busy=0, done=0.
  - Shift register, bit counter and divider counter are cleared.
  - in_ready=1 from the first cycle after reset.
  - Reset wins over every other event, including a mid-frame reset; the frame is abandoned silently with no done pulse.
- States: IDLE, START, DATA, PARITY, STOP.
- in_ready = (state==IDLE). It is combinational from state only and does not depend on in_valid.
- Accept on a posedge with in_valid=1 and in_ready=1:
  - in_data is loaded into the shift register.
  - The parity bit (XOR of in_data) is captured.
  - Next state is START, busy=1.
  - in_data is don't-care after acceptance.
- Bit timing:
  - A divider counter counts 0..DIV-1 in every non-IDLE state.
  - A state or bit advance occurs only on the cycle where the divider equals DIV-1; the divider then wraps to 0.
- START: dout=0 for DIV cycles -> DATA, bit counter=0.
- DATA:
  - dout = shift register bit 0.
  - On each advance the register shifts right by one and the bit counter increments.
  - After bit WIDTH-1 the next state is PARITY if PARITY_EN=1, else STOP.
- PARITY: dout = captured even-parity bit (1 if in_data has an odd number of ones) for DIV cycles -> STOP.
- STOP:
  - dout=1 for DIV cycles.
  - done=1 during the last of these cycles.
  - Then IDLE, busy=0.
- IDLE: dout=1.
- dout is registered: it changes on the posedge that enters a new state or bit.
- The first dout=0 appears in the cycle after the accept edge.
- Frame length is (1 + WIDTH + PARITY_EN + 1) * DIV cycles, from the cycle after accept through the done cycle.
- Back-to-back frames:
  - in_ready rises in the cycle after done.
  - With in_valid held high, the next accept occurs on that edge.
  - Minimum gap is one IDLE cycle (dout=1).
- in_valid asserted while busy is ignored; the producer holds its word until in_ready.
- Counter widths: bit counter $clog2(WIDTH)+1; divider $clog2(DIV)+1. No overflow is possible within the legal ranges.

Decomposition:
- Shared package siso_pkg holds:
  - The state enum (IDLE, START, DATA, PARITY, STOP).
  - Line-level constants LINE_IDLE=1, START_LVL=0, STOP_LVL=1.
- Sub-module siso_shreg: WIDTH-bit parallel-load, shift-right-on-enable register with serial output bit 0.
  - Ports: clk, reset, load, shift_en, pdata, sout.
- The FSM, counters and parity capture live in siso_frame_ctrl.

Test Plan:
- Basic frame: WIDTH=4, DIV=1, PARITY_EN=1, in_data=4'b1011, one-cycle in_valid.
  - dout after accept = 0,1,1,0,1,1,1 (start, d0..d3, parity, stop).
  - done high on the 7th cycle; busy high for cycles 1-7; in_ready=0 for cycles 1-7.
- Divider: DIV=3, in_data=4'b0001, PARITY_EN=1.
  - Each bit held 3 cycles: dout = 000,111,000,000,000,111,111 (start, d0-d3, parity, stop).
  - done on cycle 21.
- No parity and back-to-back: PARITY_EN=0, DIV=1, in_valid held high with 4'b1100 then 4'b0011.
  - Frame 1 dout = 0,0,0,1,1,1; one idle cycle at 1; then frame 2 = 0,1,1,0,0,1.
  - Exactly two done pulses.
- Busy-ignore: while frame 4'b1111 is transmitting, present 4'b0000 with in_valid=1 for 2 cycles, then drop in_valid.
  - Only 4'b1111 is transmitted; second frame never starts; parity bit=0.
- Mid-frame reset: assert reset=0 for one cycle during DATA bit 2.
  - Next cycle: dout=1, busy=0, in_ready=1, no done pulse.
  - A new accept afterwards transmits correctly from the start bit.
